fifo_rr_arbiter: RTL and testbench
==================================

# fifo_rr_arbiter

Round-robin drain stage that sits directly downstream of a bank of source FIFOs and upstream of a single destination FIFO. It pops words from non-empty source FIFOs and writes them into the destination FIFO. Bursts are bounded per source. It tracks the one-cycle read latency of the sources so that the destination is never overrun. Each word is tagged with the index of the source it came from.

## Interface
Parameters:
- N_SRC, 4: number of source FIFOs (power of two, 2..8).
- DATA_W, 8: word width.
- CNT_W, 4: width of the destination occupancy count.
- DST_DEPTH, 8: destination FIFO capacity in words.
- MAX_BURST, 4: maximum consecutive reads from one source before re-arbitration.
- ID_W, $clog2(N_SRC): width of the source id.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- enable, in, 1: permits new source reads.
- src_empty, in, N_SRC: per-source empty flag (combinational from the source counter).
- src_data, in, N_SRC*DATA_W: per-source registered read data. Source i occupies bits [i*DATA_W +: DATA_W].
- src_rd_en, out, N_SRC: per-source pop strobe, one-hot or zero.
- dst_count, in, CNT_W: destination occupancy.
- dst_wr_en, out, 1: destination push strobe.
- dst_data, out, DATA_W: word pushed to the destination.
- dst_src_id, out, ID_W: source index of dst_data.
- xfer_count, out, 16: total words pushed, wraps modulo 2^16.
- busy, out, 1: high while in BURST state or while a write is pending.

## Operation
- Internal state:
  - FSM with states IDLE and BURST.
  - cur, ID_W bits: currently granted source.
  - last, ID_W bits: last released source. Reset value N_SRC-1, so source 0 wins first.
  - burst_cnt: counts reads in the current burst.
  - pend_q: a read was issued last cycle.
  - pend_id: the source that read came from.
- can_issue = enable && (dst_count + pend_q < DST_DEPTH). The comparison is evaluated at CNT_W+1 bits with no overflow.
- Rotating pick: the first non-empty source, scanning from start+1 upward modulo N_SRC. start = last in IDLE, cur in BURST.
- Each cycle, the first matching rule applies:
  1. !enable: no read. Go to IDLE with last = cur. A pending write still completes.
  2. BURST && can_issue && !src_empty[cur] && burst_cnt < MAX_BURST: read cur, burst_cnt++.
  3. can_issue && any non-empty: read the pick, cur = pick, burst_cnt = 1, go to BURST. There is no bubble on switch. If cur is the only non-empty source, it is regranted.
  4. !can_issue: no read, state and burst_cnt held (stall).
  5. Otherwise (all sources empty): go to IDLE with last = cur.
- Write path, registered:
  - dst_wr_en = pend_q.
  - dst_data = src_data[pend_id].
  - dst_src_id = pend_id.
- xfer_count increments on every cycle where dst_wr_en is high.
- A read is never issued to an empty source. src_rd_en is never multi-hot.

## Timing
- Reset values: src_rd_en = 0, dst_wr_en = 0, dst_data = 0, dst_src_id = 0, xfer_count = 0, busy = 0, FSM in IDLE, last = N_SRC-1.
- Reset is asynchronous. Any in-flight write is dropped immediately.
- src_rd_en is combinational from the current state and inputs. It depends on dst_count, src_empty and enable.
- Latency:
  - Read at edge-cycle t gives dst_wr_en and dst_data at t+1, with data valid from the source's registered output.
  - Sustained throughput is 1 word/cycle.
- Destination full:
  - With dst_count = DST_DEPTH-1 and pend_q = 1, no read is issued.
  - The destination reaches exactly DST_DEPTH and is never written while full.
- Source boundary: a source at count 1 that is read at t reports empty at t+1. Rule 2 then fails, and rule 3 switches source in the same cycle.
- enable falling: the current read still lands at t+1 and no new reads are issued. When enable rises again, arbitration resumes from last+1.

## Structure
- Package fifo_arb_pkg holds:
  - the state enum (IDLE, BURST);
  - default parameter constants;
  - the xfer counter width (16).
- Sub-module rr_priority_pick: combinational rotate-and-priority-encode.
  - Inputs: req[N_SRC], start[ID_W].
  - Outputs: gnt_id[ID_W], any.
- The top level holds the FSM, the pending register, the data mux and the counter.

## Test plan
- Single word: after reset, src_empty = 4'b1110 and source 0 data 0xA5, dst_count = 0. Expect src_rd_en = 0001 for 1 cycle, next cycle dst_wr_en = 1, dst_data = 0xA5, dst_src_id = 0, xfer_count = 1.
- Burst bound: sources 0 and 2 each hold 6 words, dst_count = 0. Expect grant order 0,0,0,0,2,2,2,2,0,0,2,2 back-to-back with no idle cycles.
- Destination back-pressure:
  - dst_count held at 7, one pending read, DST_DEPTH = 8: expect src_rd_en = 0 until dst_count drops to 6.
  - Never more than 8 words outstanding.
- Source empties mid-burst: source 1 holds 2 words, source 3 holds 5. Expect 1,1 then switch to 3 with no bubble, burst_cnt restarts.
- enable deasserted during a burst, and async rst asserted with pend_q = 1:
  - After enable deassert: no new reads, the pending write completes.
  - After rst: dst_wr_en drops immediately, xfer_count = 0, and the next grant goes to source 0.

Source files
------------

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin FIFO drain stage.
// Imported by the priority picker and the top level.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int N_SRC_DEF     = 4;
  localparam int DATA_W_DEF    = 8;
  localparam int CNT_W_DEF     = 4;
  localparam int DST_DEPTH_DEF = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int XFER_W        = 16;

endpackage

// File: rtl/fifo_rr_arbiter_pick.sv
// Rotating priority pick: first set request scanning upward
// from start+1, wrapping modulo N_SRC.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic [ID_W-1:0]  gnt_id,
  output logic             any
);

  logic [ID_W-1:0] idx;

  // Scan farthest-first so the nearest candidate overwrites last.
  // N_SRC is a power of two, so the wrap is plain truncation.
  always_comb begin
    gnt_id = '0;
    any    = 1'b0;
    idx    = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = start + ID_W'(k);
      if (req[idx]) begin
        gnt_id = idx;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin drain from a bank of source FIFOs into one
// destination FIFO, with per-source burst bound and id tagging.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_SRC     = N_SRC_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DST_DEPTH = DST_DEPTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int ID_W      = $clog2(N_SRC)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [N_SRC-1:0]        src_empty,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  output logic [N_SRC-1:0]        src_rd_en,
  input  logic [CNT_W-1:0]        dst_count,
  output logic                    dst_wr_en,
  output logic [DATA_W-1:0]       dst_data,
  output logic [ID_W-1:0]         dst_src_id,
  output logic [XFER_W-1:0]       xfer_count,
  output logic                    busy
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   cur_q, cur_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic              pend_q;
  logic [ID_W-1:0]   pend_id_q;
  logic [XFER_W-1:0] xfer_q;

  logic              rd;
  logic [ID_W-1:0]   rd_id;
  logic [CNT_W:0]    occ;
  logic              can_issue;
  logic [ID_W-1:0]   start;
  logic [ID_W-1:0]   pick_id;
  logic              pick_any;

  assign occ = {1'b0, dst_count}
             + {{CNT_W{1'b0}}, pend_q};
  assign can_issue = enable
    && (occ < (CNT_W+1)'(DST_DEPTH));
  assign start = (state_q == BURST) ? cur_q : last_q;

  rr_priority_pick #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_pick (
    .req    (~src_empty),
    .start  (start),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    rd      = 1'b0;
    rd_id   = cur_q;
    if (!enable) begin
      state_d = IDLE;
      last_d  = cur_q;
    end else if (state_q == BURST && can_issue
                 && !src_empty[cur_q]
                 && bcnt_q < BC_W'(MAX_BURST)) begin
      rd     = 1'b1;
      bcnt_d = bcnt_q + BC_W'(1);
    end else if (can_issue && pick_any) begin
      rd      = 1'b1;
      rd_id   = pick_id;
      cur_d   = pick_id;
      bcnt_d  = BC_W'(1);
      state_d = BURST;
    end else if (can_issue) begin
      state_d = IDLE;
      last_d  = cur_q;
    end
  end

  // The count steps with the read so it already includes the
  // word being pushed while dst_wr_en is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cur_q     <= ID_W'(N_SRC - 1);
      last_q    <= ID_W'(N_SRC - 1);
      bcnt_q    <= '0;
      pend_q    <= 1'b0;
      pend_id_q <= '0;
      xfer_q    <= '0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      bcnt_q    <= bcnt_d;
      pend_q    <= rd;
      pend_id_q <= rd ? rd_id : pend_id_q;
      xfer_q    <= xfer_q + XFER_W'(rd);
    end
  end

  assign src_rd_en  = rd ? (N_SRC'(1) << rd_id) : '0;
  assign dst_wr_en  = pend_q;
  assign dst_data   = pend_q
    ? src_data[pend_id_q*DATA_W +: DATA_W] : '0;
  assign dst_src_id = pend_id_q;
  assign xfer_count = xfer_q;
  assign busy       = (state_q == BURST) || pend_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: queue-based sources/destination,
// rule-level reference model, directed cases plus random traffic.
module tb_fifo_rr_arbiter;
  import fifo_arb_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int CW    = 4;
  localparam int DEPTH = 8;
  localparam int MB    = 4;
  localparam int IW    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic [N-1:0]    src_empty;
  logic [N*DW-1:0] src_data;
  logic [N-1:0]    src_rd_en;
  logic [CW-1:0]   dst_count;
  logic            dst_wr_en;
  logic [DW-1:0]   dst_data;
  logic [IW-1:0]   dst_src_id;
  logic [15:0]     xfer_count;
  logic            busy;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(
    .N_SRC(N), .DATA_W(DW), .CNT_W(CW),
    .DST_DEPTH(DEPTH), .MAX_BURST(MB), .ID_W(IW)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .src_empty(src_empty), .src_data(src_data),
    .src_rd_en(src_rd_en), .dst_count(dst_count),
    .dst_wr_en(dst_wr_en), .dst_data(dst_data),
    .dst_src_id(dst_src_id), .xfer_count(xfer_count),
    .busy(busy)
  );

  logic [DW-1:0] sq [N][$];
  logic [DW-1:0] sreg [N];
  logic [DW-1:0] dq [$];

  int checks = 0;
  int failures = 0;
  int drain_mode = 0;

  int mst, mcur, mlast, mbcnt, mpend, mpid, mxfer;
  logic [DW-1:0] mword;
  int e_rd, e_id, n_st, n_cur, n_last, n_b;
  logic [DW-1:0] e_word;

  logic [N-1:0]  s_rd;
  logic          s_wr;
  logic [DW-1:0] s_data;
  logic [IW-1:0] s_id;
  int            s_xfer;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_empty[i] = (sq[i].size() == 0);
      src_data[i*DW +: DW] = sreg[i];
    end
    dst_count = CW'(dq.size());
  endtask

  function automatic int pick(int st);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (st + k) % N;
      if (sq[i].size() > 0) return i;
    end
    return -1;
  endfunction

  function automatic int oh2i(logic [N-1:0] v);
    for (int i = 0; i < N; i++)
      if (v == (N'(1) << i)) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mst = 0; mcur = N-1; mlast = N-1; mbcnt = 0;
    mpend = 0; mpid = 0; mxfer = 0; mword = '0;
  endtask

  task automatic model_eval();
    bit can;
    int pk;
    can = enable && (dq.size() + mpend < DEPTH);
    pk = pick(mst ? mcur : mlast);
    n_st = mst; n_cur = mcur; n_last = mlast; n_b = mbcnt;
    e_rd = 0; e_id = 0; e_word = '0;
    if (!enable) begin
      n_st = 0; n_last = mcur;
    end else if (mst == 1 && can && sq[mcur].size() > 0
                 && mbcnt < MB) begin
      e_rd = 1; e_id = mcur; n_b = mbcnt + 1;
    end else if (can && pk >= 0) begin
      e_rd = 1; e_id = pk; n_cur = pk; n_b = 1; n_st = 1;
    end else if (can) begin
      n_st = 0; n_last = mcur;
    end
    if (e_rd != 0) e_word = sq[e_id][0];
  endtask

  task automatic tick();
    @(negedge clk);
    model_eval();
    s_rd = src_rd_en; s_wr = dst_wr_en;
    s_data = dst_data; s_id = dst_src_id;
    s_xfer = int'(xfer_count);
    chk("src_rd_en", int'(src_rd_en),
        e_rd != 0 ? (1 << e_id) : 0);
    chk("dst_wr_en", int'(dst_wr_en), mpend);
    if (mpend != 0) begin
      chk("dst_data", int'(dst_data), int'(mword));
      chk("dst_src_id", int'(dst_src_id), mpid);
    end
    chk("xfer_count", s_xfer, mxfer % 65536);
    chk("busy", int'(busy), (mst == 1 || mpend != 0) ? 1 : 0);
    @(posedge clk);
    if (s_wr) begin
      chk("dst_overrun", dq.size() >= DEPTH ? 1 : 0, 0);
      dq.push_back(s_data);
    end
    for (int i = 0; i < N; i++) begin
      if (s_rd[i]) begin
        chk("pop_empty", sq[i].size() == 0 ? 1 : 0, 0);
        if (sq[i].size() > 0) sreg[i] = sq[i].pop_front();
      end
    end
    mpend = e_rd; mpid = e_id; mword = e_word;
    mxfer = mxfer + e_rd;
    mst = n_st; mcur = n_cur; mlast = n_last; mbcnt = n_b;
    if (dq.size() > 0 && (drain_mode == 1 ||
        (drain_mode == 2 && $urandom_range(0, 1) == 1)))
      void'(dq.pop_front());
    #1 drive();
  endtask

  task automatic do_reset(input bit clr);
    rst = 1'b1;
    enable = 1'b0;
    #1;
    chk("rst_rd_en", int'(src_rd_en), 0);
    chk("rst_wr_en", int'(dst_wr_en), 0);
    chk("rst_data", int'(dst_data), 0);
    chk("rst_id", int'(dst_src_id), 0);
    chk("rst_xfer", int'(xfer_count), 0);
    chk("rst_busy", int'(busy), 0);
    if (clr) begin
      for (int i = 0; i < N; i++) sq[i].delete();
      dq.delete();
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
  endtask

  int exp_burst [12] = '{0,0,0,0,2,2,2,2,0,0,2,2};
  int exp_mid   [7]  = '{1,1,3,3,3,3,3};

  initial begin
    #1_000_000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < N; i++) sreg[i] = '0;
    drive();
    model_reset();

    // single word
    do_reset(1);
    sq[0].push_back(8'hA5);
    enable = 1'b1;
    drive();
    tick();
    chk("t1_rd", int'(s_rd), 1);
    tick();
    chk("t1_wr", int'(s_wr), 1);
    chk("t1_data", int'(s_data), 'hA5);
    chk("t1_id", int'(s_id), 0);
    chk("t1_xfer", s_xfer, 1);
    repeat (2) tick();

    // burst bound, sources 0 and 2
    do_reset(1);
    drain_mode = 1;
    for (int w = 0; w < 6; w++) begin
      sq[0].push_back(DW'($urandom));
      sq[2].push_back(DW'($urandom));
    end
    enable = 1'b1;
    drive();
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("burst_g%0d", c), oh2i(s_rd), exp_burst[c]);
    end
    repeat (3) tick();

    // destination back-pressure
    do_reset(1);
    drain_mode = 0;
    for (int w = 0; w < 12; w++) sq[1].push_back(DW'($urandom));
    enable = 1'b1;
    drive();
    repeat (12) tick();
    chk("bp_full", dq.size(), 8);
    chk("bp_stall", int'(s_rd), 0);
    void'(dq.pop_front());
    drive();
    tick();
    chk("bp_at7_rd", int'(s_rd), 4'b0010);
    tick();
    chk("bp_7pend_rd", int'(s_rd), 0);
    void'(dq.pop_front());
    void'(dq.pop_front());
    drive();
    tick();
    chk("bp_at6_rd", int'(s_rd), 4'b0010);
    drain_mode = 1;
    repeat (12) tick();

    // source empties mid-burst
    do_reset(1);
    for (int w = 0; w < 2; w++) sq[1].push_back(DW'($urandom));
    for (int w = 0; w < 5; w++) sq[3].push_back(DW'($urandom));
    enable = 1'b1;
    drive();
    for (int c = 0; c < 7; c++) begin
      tick();
      chk($sformatf("mid_g%0d", c), oh2i(s_rd), exp_mid[c]);
    end
    repeat (2) tick();

    // enable drop mid-burst, then async reset with a pending write
    do_reset(1);
    for (int w = 0; w < 6; w++) begin
      sq[0].push_back(DW'($urandom));
      sq[2].push_back(DW'($urandom));
    end
    enable = 1'b1;
    drive();
    repeat (2) tick();
    enable = 1'b0;
    drive();
    tick();
    chk("en_off_rd", int'(s_rd), 0);
    chk("en_off_wr", int'(s_wr), 1);
    tick();
    chk("en_off_wr2", int'(s_wr), 0);
    enable = 1'b1;
    drive();
    tick();
    chk("en_resume", int'(s_rd), 4'b0100);
    chk("pre_rst_wr", int'(dst_wr_en), 1);
    do_reset(0);
    enable = 1'b1;
    drive();
    tick();
    chk("post_rst_rd", int'(s_rd), 4'b0001);
    repeat (4) tick();

    // random traffic
    do_reset(1);
    drain_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (sq[i].size() < 10 && $urandom_range(0, 2) == 0)
          sq[i].push_back(DW'($urandom));
      enable = ($urandom_range(0, 15) != 0);
      drive();
      tick();
    end
    enable = 1'b1;
    drain_mode = 1;
    drive();
    repeat (60) tick();
    chk("final_src_drained",
        sq[0].size() + sq[1].size() + sq[2].size() + sq[3].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
